carry_skip_seq_adder: RTL and testbench

//  Multi-cycle WIDTH-bit adder that reuses one 4-bit carry-skip slice.
//  The slice is a 4-bit ripple adder whose carry-out is bypassed to cin when all four propagate bits are 1.
//  The block accepts operands on a valid/ready handshake and feeds the slice one nibble per cycle, LSB first.
//  It chains the carry through a register and returns the full sum and carry on a second valid/ready handshake.

---
 rtl/carry_skip_seq_adder_if.sv | 35 +++
 rtl/carry_skip_seq_adder.sv | 124 ++++++++++++
 tb/tb_carry_skip_seq_adder.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/carry_skip_seq_adder_if.sv
`default_nettype none
// ============================================================================
//  Module      : carry_skip_seq_adder_if
//  Description : Operand/result handshake bundle for carry_skip_seq_adder.
//  Revision    : 1.0  initial release
// ============================================================================
interface carry_skip_seq_adder_if #(
    parameter int WIDTH = 16
);
    localparam int NSLICE = WIDTH / 4;
    localparam int CNT_W  = $clog2(NSLICE + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [CNT_W-1:0] skip_cnt;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, skip_cnt, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, skip_cnt, busy
    );
endinterface
`default_nettype wire

// File: rtl/carry_skip_seq_adder.sv
`default_nettype none
// ============================================================================
//  Module      : carry_skip_seq_adder
//  Description : WIDTH-bit adder built from one 4-bit carry-skip slice reused
//                once per nibble, LSB first, with valid/ready on both sides.
//  Revision    : 1.0  initial release
// ============================================================================
module carry_skip_seq_adder #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    carry_skip_seq_adder_if.slave bus
);
    localparam int NSLICE = WIDTH / 4;
    localparam int CNT_W  = $clog2(NSLICE + 1);
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);
    localparam logic [WIDTH-1:0] NIB_MASK = WIDTH'(4'hF);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_skip;

    logic [IDX_W+1:0] w_sh;
    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_p;
    logic [3:0]       w_s;
    logic             w_ripple_c;
    logic             w_skip;
    logic             w_slice_cout;
    logic             w_last;

    assign w_sh    = {r_idx, 2'b00};
    assign w_a_nib = 4'(r_a >> w_sh);
    assign w_b_nib = 4'(r_b >> w_sh);
    assign w_p     = w_a_nib ^ w_b_nib;
    assign w_last  = (r_idx == LAST_IDX);

    always_comb begin
        logic c;
        w_s = 4'h0;
        c   = r_carry;
        for (int i = 0; i < 4; i++) begin
            w_s[i] = w_p[i] ^ c;
            c      = (w_a_nib[i] & w_b_nib[i]) | (c & w_p[i]);
        end
        w_ripple_c = c;
    end

    // All-propagate nibble: carry bypasses the ripple chain straight from cin.
    assign w_skip       = (w_p == 4'hF);
    assign w_slice_cout = w_skip ? r_carry : w_ripple_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last)        w_state_nxt = S_DONE;
            S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
            r_skip  <= '0;
        end else if (r_state == S_IDLE) begin
            if (bus.in_valid) begin
                r_a     <= bus.a;
                r_b     <= bus.b;
                r_carry <= bus.cin;
                r_sum   <= '0;
                r_skip  <= '0;
                r_idx   <= '0;
            end
        end else if (r_state == S_RUN) begin
            r_sum   <= (r_sum & ~(NIB_MASK << w_sh)) | (WIDTH'(w_s) << w_sh);
            r_carry <= w_slice_cout;
            r_idx   <= r_idx + IDX_W'(1);
            if (w_skip) begin
                r_skip <= r_skip + CNT_W'(1);
            end
            if (w_last) begin
                r_cout <= w_slice_cout;
            end
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state == S_RUN) || (r_state == S_DONE);
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.skip_cnt  = r_skip;
endmodule
`default_nettype wire

// File: tb/tb_carry_skip_seq_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_carry_skip_seq_adder
//  Description : Self-checking bench; three adders (WIDTH 4, 16, 32) against
//                an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_carry_skip_seq_adder;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [2:0]  d_in_valid;
    logic [2:0]  d_out_ready;
    logic [2:0]  d_cin;
    logic [31:0] d_a [3];
    logic [31:0] d_b [3];
    wire  [2:0]  d_in_ready;
    wire  [2:0]  d_out_valid;
    wire  [2:0]  d_busy;
    wire  [2:0]  d_cout;
    wire  [31:0] d_sum  [3];
    wire  [3:0]  d_skip [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WG = (g == 0) ? 4 : (g == 1) ? 16 : 32;
        carry_skip_seq_adder_if #(.WIDTH(WG)) bus ();

        assign bus.in_valid  = d_in_valid[g];
        assign bus.out_ready = d_out_ready[g];
        assign bus.cin       = d_cin[g];
        assign bus.a         = d_a[g][WG-1:0];
        assign bus.b         = d_b[g][WG-1:0];
        assign d_in_ready[g]  = bus.in_ready;
        assign d_out_valid[g] = bus.out_valid;
        assign d_busy[g]      = bus.busy;
        assign d_cout[g]      = bus.cout;
        assign d_sum[g]       = 32'(bus.sum);
        assign d_skip[g]      = 4'(bus.skip_cnt);

        carry_skip_seq_adder #(.WIDTH(WG)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int width_of(input int k);
        return (k == 0) ? 4 : (k == 1) ? 16 : 32;
    endfunction

    // Reference: {skip, cout, sum} from plain integer addition and nibble XOR.
    function automatic logic [36:0] ref_add(input int k, input logic [31:0] a,
                                            input logic [31:0] b, input logic c);
        logic [32:0] full;
        logic [31:0] m;
        logic [31:0] p;
        logic [3:0]  skip;
        int          w;
        w    = width_of(k);
        m    = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        full = {1'b0, a & m} + {1'b0, b & m} + 33'(c);
        p    = a ^ b;
        skip = 4'd0;
        for (int n = 0; n < w / 4; n++) begin
            if (((p >> (4 * n)) & 32'hF) == 32'hF) skip = skip + 4'd1;
        end
        return {skip, full[w], full[31:0] & m};
    endfunction

    // Starts between a negedge and the next posedge with the DUT idle; ends on a negedge, idle.
    task automatic run_txn(input int k, input logic [31:0] a, input logic [31:0] b,
                           input logic c, input bit rand_bp, input string name);
        logic [36:0] exp;
        int          cyc;
        exp = ref_add(k, a, b, c);
        checks++;
        if (d_in_ready[k] !== 1'b1) begin
            failures++;
            $display("FAIL %s_in_ready k=%0d got=%b exp=1", name, k, d_in_ready[k]);
        end
        d_a[k] = a; d_b[k] = b; d_cin[k] = c; d_in_valid[k] = 1'b1; d_out_ready[k] = 1'b0;
        @(negedge clk);
        d_in_valid[k] = 1'b0;
        d_a[k] = $urandom; d_b[k] = $urandom; d_cin[k] = 1'($urandom);
        cyc = 0;
        while (d_out_valid[k] !== 1'b1 && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != width_of(k) / 4) begin
            failures++;
            $display("FAIL %s_latency k=%0d got=%0d exp=%0d", name, k, cyc, width_of(k) / 4);
        end
        checks++;
        if ({d_skip[k], d_cout[k], d_sum[k]} !== exp || d_busy[k] !== 1'b1) begin
            failures++;
            $display("FAIL %s_result k=%0d got skip=%0d cout=%b sum=%h busy=%b exp skip=%0d cout=%b sum=%h busy=1",
                     name, k, d_skip[k], d_cout[k], d_sum[k], d_busy[k], exp[36:33], exp[32], exp[31:0]);
        end
        for (int i = 0; i < 40; i++) begin
            d_out_ready[k] = rand_bp ? ($urandom_range(0, 2) == 0) : 1'b1;
            if (i == 39) d_out_ready[k] = 1'b1;
            @(negedge clk);
            if (d_out_ready[k]) break;
            checks++;
            if (d_out_valid[k] !== 1'b1 || {d_skip[k], d_cout[k], d_sum[k]} !== exp) begin
                failures++;
                $display("FAIL %s_hold k=%0d got valid=%b sum=%h exp valid=1 sum=%h",
                         name, k, d_out_valid[k], d_sum[k], exp[31:0]);
            end
        end
        d_out_ready[k] = 1'b0;
        checks++;
        if (d_out_valid[k] !== 1'b0 || d_in_ready[k] !== 1'b1) begin
            failures++;
            $display("FAIL %s_pop k=%0d got valid=%b ready=%b exp valid=0 ready=1",
                     name, k, d_out_valid[k], d_in_ready[k]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({d_sum[k], d_cout[k], d_skip[k], d_out_valid[k], d_busy[k]} !== '0) begin
                failures++;
                $display("FAIL reset_outputs k=%0d got sum=%h cout=%b skip=%0d valid=%b busy=%b exp all 0",
                         k, d_sum[k], d_cout[k], d_skip[k], d_out_valid[k], d_busy[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (d_in_ready !== 3'b111) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=111", d_in_ready);
        end
    endtask

    task automatic test_directed();
        run_txn(1, 32'hFFFF, 32'h0001, 1'b0, 1'b0, "dir_ffff_1");
        run_txn(1, 32'h1234, 32'h4321, 1'b1, 1'b0, "dir_1234");
        run_txn(1, 32'h8000, 32'h8000, 1'b0, 1'b0, "dir_8000");
        run_txn(1, 32'h5555, 32'hAAAA, 1'b1, 1'b0, "dir_5555");
        run_txn(0, 32'hF, 32'h0, 1'b1, 1'b0, "dir_w4_skip");
        run_txn(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "dir_w32_wrap");
    endtask

    task automatic test_backpressure();
        logic [36:0] exp;
        int          cyc;
        exp = ref_add(1, 32'h9F0F, 32'h60F1, 1'b0);
        d_a[1] = 32'h9F0F; d_b[1] = 32'h60F1; d_cin[1] = 1'b0; d_in_valid[1] = 1'b1;
        @(negedge clk);
        d_in_valid[1] = 1'b0;
        cyc = 0;
        while (d_out_valid[1] !== 1'b1 && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        for (int i = 0; i < 5; i++) begin
            d_in_valid[1] = ~d_in_valid[1];
            d_a[1] = $urandom; d_b[1] = $urandom; d_cin[1] = 1'($urandom);
            @(negedge clk);
            checks++;
            if (d_in_ready[1] !== 1'b0 || d_out_valid[1] !== 1'b1 ||
                {d_skip[1], d_cout[1], d_sum[1]} !== exp) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got ready=%b valid=%b sum=%h cout=%b skip=%0d exp ready=0 valid=1 sum=%h cout=%b skip=%0d",
                         i, d_in_ready[1], d_out_valid[1], d_sum[1], d_cout[1], d_skip[1],
                         exp[31:0], exp[32], exp[36:33]);
            end
        end
        // Operand offered on the pop edge must not be taken.
        d_in_valid[1] = 1'b1; d_a[1] = 32'h1111; d_b[1] = 32'h2222;
        d_out_ready[1] = 1'b1;
        @(negedge clk);
        d_out_ready[1] = 1'b0;
        d_in_valid[1]  = 1'b0;
        checks++;
        if (d_in_ready[1] !== 1'b1 || d_busy[1] !== 1'b0 || d_out_valid[1] !== 1'b0) begin
            failures++;
            $display("FAIL bp_pop got ready=%b busy=%b valid=%b exp ready=1 busy=0 valid=0",
                     d_in_ready[1], d_busy[1], d_out_valid[1]);
        end
        run_txn(1, 32'h0F0F, 32'hF0F0, 1'b1, 1'b0, "bp_next");
    endtask

    task automatic test_reset_mid_run();
        d_a[1] = 32'hF0F0; d_b[1] = 32'h0F0F; d_cin[1] = 1'b0; d_in_valid[1] = 1'b1;
        @(negedge clk);
        d_in_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({d_sum[1], d_cout[1], d_skip[1], d_out_valid[1], d_busy[1]} !== '0) begin
            failures++;
            $display("FAIL midrun_reset got sum=%h cout=%b skip=%0d valid=%b busy=%b exp all 0",
                     d_sum[1], d_cout[1], d_skip[1], d_out_valid[1], d_busy[1]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(1, 32'h0F0F, 32'h00F1, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_random(input int k);
        logic [31:0] a;
        logic [31:0] b;
        for (int n = 0; n < 1000; n++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? ~a : $urandom;
            run_txn(k, a, b, 1'($urandom), 1'b1, "rand");
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0;
        d_in_valid = '0; d_out_ready = '0; d_cin = '0;
        for (int k = 0; k < 3; k++) begin
            d_a[k] = '0;
            d_b[k] = '0;
        end
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_random(0);
        test_random(1);
        test_random(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
